mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares one single-port synchronous RAM (16-bit × 256, registered address, unregistered q) between the CPU memory port and an I/O/DMA port. Each requester sees a simple req/ack interface. The arbiter serialises accesses, drives the RAM address/data/write-enable from registers, and returns read data with a one-cycle ack pulse. It sits between the CPU16 core, the I/O controller and the altsyncram instance in the top level.

## Interface
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 16, RAM/requester data width
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock (`clock`); reset is synchronous and active-high
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_WIDTH  CPU address; stable while cpu_req
- cpu_wdata  in  DATA_WIDTH  CPU write data; stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ack=1 and held until next CPU completion
- io_req, io_we, io_addr, io_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  same rules as the CPU port
- io_ack, io_rdata  out  1/DATA_WIDTH  same rules as the CPU port
- mem_address  out  ADDR_WIDTH  registered RAM address
- mem_data  out  DATA_WIDTH  registered RAM write data
- mem_wren  out  1  registered RAM write enable
- mem_q  in  DATA_WIDTH  RAM read data; valid in the cycle after the address edge
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Eligible requesters: req=1 and the port's own ack not currently high. The ack-high cycle is the requester's cycle to drop req.
  - None eligible: stay in IDLE.
  - One eligible: grant that port.
  - Both eligible: grant the port not named by last_grant (round robin). Update last_grant.
  - On grant: register mem_address←addr, mem_data←wdata, mem_wren←we, owner←port. Go to ACCESS.
- ACCESS: mem_* held stable. The RAM samples them at the closing edge; that edge clears mem_wren. Go to RESP.
- RESP: mem_q is valid. At the closing edge:
  - owner's ack←1.
  - owner's rdata←mem_q for reads; rdata is unchanged for writes.
  - Go to IDLE.
- Acks are registered pulses that last exactly one cycle. At most one ack is high in any cycle.
- The non-owner port's rdata never changes.
- Writes: RAM content is updated at the ACCESS closing edge. A read of the same address in a later access returns the new value.
- Requester inputs are sampled only at the grant edge. Changes after the grant are ignored until the next grant.

## Timing
- Reset values: state=IDLE, last_grant=io (so the CPU wins the first tie), mem_address=0, mem_data=0, mem_wren=0, cpu_ack=io_ack=0, cpu_rdata=io_rdata=0, busy=0.
- Latency: req high at edge E0 (in IDLE) → mem_* valid after E0 → RAM samples at E1 → ack and rdata valid after E2. Ack is high in the cycle between E2 and E3.
- Throughput: one access per 3 cycles. The IDLE cycle carrying an ack arbitrates again, so the other port can be granted at E3.
- A single requester re-asserting immediately after its ack:
  - It is ineligible in the ack cycle.
  - Its next grant is one cycle later, so 4-cycle spacing.
- Simultaneous requests while busy: held; the tie is resolved at the next IDLE.
- Reset mid-operation:
  - Any state returns to IDLE with no ack issued.
  - If reset coincides with the ACCESS closing edge, the write in flight commits to RAM because mem_wren was high at that edge.
  - Requesters must reissue after reset.
- Address arithmetic: none. Addresses pass through unmodified; 0xFF is a valid address with no wrap logic.

## Test plan
- Reset then CPU read: RAM[0x10]=0x1234. cpu_req=1, we=0, addr=0x10 at E0 → cpu_ack=1 and cpu_rdata=0x1234 after E2. io_ack stays 0.
- IO write then CPU read-back:
  - io write 0x05←0xBEEF completes with io_ack, and io_rdata stays unchanged.
  - Then a CPU read of 0x05 returns 0xBEEF.
- Tie after reset: both req at E0 → CPU granted first (ack after E2), IO granted at E3 (ack after E5).
- Sustained contention: both ports hold req for 12 accesses → grants alternate CPU, IO, CPU, …. No port is granted twice in a row; acks never overlap.
- Back-to-back single port: CPU re-asserts in its ack cycle → next grant is one cycle later, so acks are 4 cycles apart. Address 0xFF reads correctly.
- Reset in ACCESS during an IO write of 0x22←0x00AA → no io_ack, busy=0 next cycle. A subsequent read of 0x22 returns 0x00AA.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin req/ack arbiter sharing one single-port synchronous RAM between a CPU port and an I/O port.
// Grant to ack takes 3 cycles, one access per 3 cycles; requesters hold req until their one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  io_req,
  input  logic                  io_we,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  output logic                  io_ack,
  output logic [DATA_WIDTH-1:0] io_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_last_io;
  logic                  r_owner_io;
  logic                  r_owner_we;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_mem_wren;
  logic                  r_cpu_ack;
  logic                  r_io_ack;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_io_rdata;

  logic w_cpu_elig;
  logic w_io_elig;
  logic w_grant;
  logic w_grant_io;

  // A port is blind during its own ack cycle so it has time to drop req.
  assign w_cpu_elig = cpu_req & ~r_cpu_ack;
  assign w_io_elig  = io_req  & ~r_io_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_io  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cpu_elig | w_io_elig) begin
          w_grant     = 1'b1;
          // On a tie, the port that did not win last time goes first.
          w_grant_io  = w_io_elig & (~w_cpu_elig | ~r_last_io);
          w_state_nxt = ACCESS;
        end
      end
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_io     <= 1'b1;
      r_owner_io    <= 1'b0;
      r_owner_we    <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_wren    <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_io_ack      <= 1'b0;
      r_cpu_rdata   <= '0;
      r_io_rdata    <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_io_ack  <= 1'b0;

      if (w_grant) begin
        r_mem_address <= w_grant_io ? io_addr  : cpu_addr;
        r_mem_data    <= w_grant_io ? io_wdata : cpu_wdata;
        r_mem_wren    <= w_grant_io ? io_we    : cpu_we;
        r_owner_we    <= w_grant_io ? io_we    : cpu_we;
        r_owner_io    <= w_grant_io;
        r_last_io     <= w_grant_io;
      end

      // The RAM has sampled the write at this edge; drop wren so it cannot repeat.
      if (r_state == ACCESS) begin
        r_mem_wren <= 1'b0;
      end

      if (r_state == RESP) begin
        if (r_owner_io) begin
          r_io_ack <= 1'b1;
          if (!r_owner_we) begin
            r_io_rdata <= mem_q;
          end
        end else begin
          r_cpu_ack <= 1'b1;
          if (!r_owner_we) begin
            r_cpu_rdata <= mem_q;
          end
        end
      end
    end
  end

  assign cpu_ack     = r_cpu_ack;
  assign cpu_rdata   = r_cpu_rdata;
  assign io_ack      = r_io_ack;
  assign io_rdata    = r_io_rdata;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign mem_wren    = r_mem_wren;
  assign busy        = (r_state != IDLE);

endmodule
